// File: rtl/glb_bank_alloc_pkg.sv
// Shared GLB definitions: default geometry, derived index widths and the allocator FSM states.
package glb_bank_alloc_pkg;

  localparam int unsigned NUM_BANK   = 16;
  localparam int unsigned NUM_PORT   = 24;
  localparam int unsigned BANK_W     = $clog2(NUM_BANK);
  localparam int unsigned PORT_W     = $clog2(NUM_PORT);
  localparam int unsigned CNT_W      = BANK_W + 1;
  localparam int unsigned SRCH_SUM_W = BANK_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RSP
  } state_e;

endpackage

// File: rtl/glb_win_free_chk.sv
// Combinational test that the window of win_num banks starting at start_idx is fully free.
module glb_win_free_chk #(
  parameter int unsigned NUM_BANK = 16
) (
  input  logic [NUM_BANK-1:0]         free_map,
  input  logic [$clog2(NUM_BANK)-1:0] start_idx,
  input  logic [$clog2(NUM_BANK):0]   win_num,
  output logic                        win_free_c,
  output logic [NUM_BANK-1:0]         win_mask_c
);

  localparam int unsigned SUM_W = $clog2(NUM_BANK) + 2;

  logic [SUM_W-1:0] win_end;

  // Windows never wrap: one that runs past the last bank is never free.
  always_comb begin
    win_end    = SUM_W'(start_idx) + SUM_W'(win_num);
    win_mask_c = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      win_mask_c[b] = (SUM_W'(b) >= SUM_W'(start_idx)) && (SUM_W'(b) < win_end);
    end
    win_free_c = ((win_mask_c & ~free_map) == '0) && (win_num != '0) &&
                 (win_end <= SUM_W'(NUM_BANK));
  end

endmodule

// File: rtl/glb_bank_alloc.sv
// GLB bank allocator: first-fit contiguous bank allocation per port, with whole-port release.
module glb_bank_alloc #(
  parameter int unsigned NUM_BANK = glb_bank_alloc_pkg::NUM_BANK,
  parameter int unsigned NUM_PORT = glb_bank_alloc_pkg::NUM_PORT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           AllocReqVld,
  output logic                           AllocReqRdy,
  input  logic [$clog2(NUM_PORT)-1:0]    AllocReqPort,
  input  logic [$clog2(NUM_BANK):0]      AllocReqNumBank,
  output logic                           AllocRspVld,
  input  logic                           AllocRspRdy,
  output logic                           AllocRspOk,
  output logic [$clog2(NUM_BANK)-1:0]    AllocRsp1stBank,
  input  logic                           RlsVld,
  output logic                           RlsRdy,
  input  logic [$clog2(NUM_PORT)-1:0]    RlsPort,
  output logic [NUM_PORT*NUM_BANK-1:0]   CfgPortBankFlag,
  output logic [NUM_BANK-1:0]            FreeBankMap
);

  import glb_bank_alloc_pkg::*;

  localparam int unsigned IDX_W     = $clog2(NUM_BANK);
  localparam int unsigned NUM_W     = IDX_W + 1;
  localparam int unsigned SUM_W     = IDX_W + 2;
  localparam int unsigned PRT_W     = $clog2(NUM_PORT);
  localparam int unsigned PRT_EXT_W = PRT_W + 1;

  state_e                             state_q, state_d;
  logic [PRT_W-1:0]                   port_q, port_d;
  logic [NUM_W-1:0]                   num_q, num_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_PORT-1:0][NUM_BANK-1:0]  flag_q, flag_d;
  logic                               vld_q, vld_d;
  logic                               ok_q, ok_d;
  logic [IDX_W-1:0]                   first_q, first_d;

  logic                               own_any_c;
  logic                               req_bad_c;
  logic                               srch_end_c;
  logic [NUM_BANK-1:0]                free_map_c;
  logic                               win_free_c;
  logic [NUM_BANK-1:0]                win_mask_c;

  glb_win_free_chk #(
    .NUM_BANK (NUM_BANK)
  ) u_win_free_chk (
    .free_map   (free_map_c),
    .start_idx  (idx_q),
    .win_num    (num_q),
    .win_free_c (win_free_c),
    .win_mask_c (win_mask_c)
  );

  // Free-bank map, requester ownership and immediate-reject decode.
  always_comb begin
    free_map_c = '1;
    own_any_c  = 1'b0;
    for (int p = 0; p < NUM_PORT; p++) begin
      free_map_c = free_map_c & ~flag_q[p];
      if (PRT_W'(p) == AllocReqPort) own_any_c = own_any_c | (|flag_q[p]);
    end
    req_bad_c  = (AllocReqNumBank == '0) ||
                 (AllocReqNumBank > NUM_W'(NUM_BANK)) ||
                 ({1'b0, AllocReqPort} >= PRT_EXT_W'(NUM_PORT)) ||
                 own_any_c;
    srch_end_c = (SUM_W'(idx_q) + SUM_W'(num_q)) >= SUM_W'(NUM_BANK);
  end

  assign AllocReqRdy     = rst_n & (state_q == IDLE) & ~RlsVld;
  assign RlsRdy          = rst_n & (state_q == IDLE);
  assign AllocRspVld     = vld_q;
  assign AllocRspOk      = ok_q;
  assign AllocRsp1stBank = first_q;
  assign CfgPortBankFlag = flag_q;
  assign FreeBankMap     = free_map_c;

  // Next-state, search datapath and ownership-map updates.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    num_d   = num_q;
    idx_d   = idx_q;
    flag_d  = flag_q;
    vld_d   = vld_q;
    ok_d    = ok_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (RlsVld) begin
          for (int p = 0; p < NUM_PORT; p++) begin
            if (PRT_W'(p) == RlsPort) flag_d[p] = '0;
          end
        end else if (AllocReqVld) begin
          port_d = AllocReqPort;
          num_d  = AllocReqNumBank;
          idx_d  = '0;
          if (req_bad_c) begin
            state_d = RSP;
            vld_d   = 1'b1;
            ok_d    = 1'b0;
            first_d = '0;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (win_free_c) begin
          for (int p = 0; p < NUM_PORT; p++) begin
            if (PRT_W'(p) == port_q) flag_d[p] = flag_q[p] | win_mask_c;
          end
          state_d = RSP;
          vld_d   = 1'b1;
          ok_d    = 1'b1;
          first_d = idx_q;
        end else if (srch_end_c) begin
          state_d = RSP;
          vld_d   = 1'b1;
          ok_d    = 1'b0;
          first_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RSP: begin
        if (AllocRspRdy) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          ok_d    = 1'b0;
          first_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      port_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      flag_q  <= '0;
      vld_q   <= 1'b0;
      ok_q    <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      flag_q  <= flag_d;
      vld_q   <= vld_d;
      ok_q    <= ok_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_glb_bank_alloc.sv
// Self-checking bench for glb_bank_alloc: directed scenarios plus random traffic against a bank-owner model.
module tb_glb_bank_alloc;

  localparam int NB = 16;
  localparam int NP = 24;
  localparam int PW = 5;
  localparam int CW = 5;
  localparam int BW = 4;
  localparam int FW = NB * NP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          AllocReqVld;
  logic          AllocReqRdy;
  logic [PW-1:0] AllocReqPort;
  logic [CW-1:0] AllocReqNumBank;
  logic          AllocRspVld;
  logic          AllocRspRdy;
  logic          AllocRspOk;
  logic [BW-1:0] AllocRsp1stBank;
  logic          RlsVld;
  logic          RlsRdy;
  logic [PW-1:0] RlsPort;
  logic [FW-1:0] CfgPortBankFlag;
  logic [NB-1:0] FreeBankMap;

  always #5 clk = ~clk;

  glb_bank_alloc #(
    .NUM_BANK (NB),
    .NUM_PORT (NP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .AllocReqVld     (AllocReqVld),
    .AllocReqRdy     (AllocReqRdy),
    .AllocReqPort    (AllocReqPort),
    .AllocReqNumBank (AllocReqNumBank),
    .AllocRspVld     (AllocRspVld),
    .AllocRspRdy     (AllocRspRdy),
    .AllocRspOk      (AllocRspOk),
    .AllocRsp1stBank (AllocRsp1stBank),
    .RlsVld          (RlsVld),
    .RlsRdy          (RlsRdy),
    .RlsPort         (RlsPort),
    .CfgPortBankFlag (CfgPortBankFlag),
    .FreeBankMap     (FreeBankMap)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int owner[NB];

  task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_flags();
    logic [FW-1:0] v = '0;
    for (int b = 0; b < NB; b++) if (owner[b] >= 0) v[owner[b]*NB + b] = 1'b1;
    return v;
  endfunction

  function automatic logic [NB-1:0] model_free();
    logic [NB-1:0] v = '0;
    for (int b = 0; b < NB; b++) v[b] = (owner[b] < 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) owner[b] = -1;
  endtask

  task automatic model_release(input int port);
    for (int b = 0; b < NB; b++) if (owner[b] == port) owner[b] = -1;
  endtask

  // First-fit search over windows [s, s+n-1]; one cycle per window tried.
  task automatic model_alloc(input int port, input int n, output bit ok, output int first, output int lat);
    bit owns = 1'b0;
    for (int b = 0; b < NB; b++) if (owner[b] == port) owns = 1'b1;
    ok = 1'b0; first = 0;
    if (n == 0 || n > NB || port >= NP || owns) begin
      lat = 1;
      return;
    end
    lat = (NB - n) + 2;
    for (int s = 0; s + n <= NB; s++) begin
      bit all_free = 1'b1;
      for (int b = s; b < s + n; b++) if (owner[b] >= 0) all_free = 1'b0;
      if (all_free) begin
        ok = 1'b1; first = s; lat = s + 2;
        for (int b = s; b < s + n; b++) owner[b] = port;
        return;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_release(input int port);
    RlsVld  = 1'b1;
    RlsPort = PW'(port);
    #1;
    check("rls_rdy", FW'(RlsRdy), FW'(1));
    check("rls_alloc_rdy", FW'(AllocReqRdy), FW'(0));
    step();
    RlsVld = 1'b0;
    if (port < NP) model_release(port);
    check("rls_flags", CfgPortBankFlag, model_flags());
    check("rls_free", FW'(FreeBankMap), FW'(model_free()));
  endtask

  task automatic do_alloc(input int port, input int n, input int hold,
                          output bit ok_o, output int first_o, output int lat_o);
    bit eok;
    int efirst, elat, lat;
    AllocReqVld     = 1'b1;
    AllocReqPort    = PW'(port);
    AllocReqNumBank = CW'(n);
    #1;
    check("req_rdy", FW'(AllocReqRdy), FW'(1));
    step();
    AllocReqVld = 1'b0;
    model_alloc(port, n, eok, efirst, elat);
    lat = 1;
    while (!AllocRspVld && lat < 40) begin
      step();
      lat++;
    end
    check("rsp_vld", FW'(AllocRspVld), FW'(1));
    check("rsp_lat", FW'(lat), FW'(elat));
    check("rsp_ok", FW'(AllocRspOk), FW'(eok));
    check("rsp_1st", FW'(AllocRsp1stBank), FW'(efirst));
    ok_o = AllocRspOk; first_o = int'(AllocRsp1stBank); lat_o = lat;
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_vld", FW'(AllocRspVld), FW'(1));
      check("hold_ok", FW'(AllocRspOk), FW'(eok));
      check("hold_1st", FW'(AllocRsp1stBank), FW'(efirst));
    end
    check("alloc_flags", CfgPortBankFlag, model_flags());
    check("alloc_free", FW'(FreeBankMap), FW'(model_free()));
    AllocRspRdy = 1'b1;
    step();
    AllocRspRdy = 1'b0;
    check("rsp_done", FW'(AllocRspVld), FW'(0));
    check("back_idle", FW'(AllocReqRdy), FW'(1));
  endtask

  initial begin
    bit ok;
    int first, lat;
    rst_n = 1'b0; AllocReqVld = 1'b0; AllocReqPort = '0; AllocReqNumBank = '0;
    AllocRspRdy = 1'b0; RlsVld = 1'b0; RlsPort = '0;
    model_reset();
    step(); step();
    check("rst_vld", FW'(AllocRspVld), FW'(0));
    check("rst_ok", FW'(AllocRspOk), FW'(0));
    check("rst_1st", FW'(AllocRsp1stBank), FW'(0));
    check("rst_flags", CfgPortBankFlag, FW'(0));
    check("rst_free", FW'(FreeBankMap), FW'(16'hFFFF));
    check("rst_req_rdy", FW'(AllocReqRdy), FW'(0));
    check("rst_rls_rdy", FW'(RlsRdy), FW'(0));
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", FW'(AllocReqRdy), FW'(1));
    step();

    do_alloc(3, 4, 0, ok, first, lat);
    check("s1_ok", FW'(ok), FW'(1)); check("s1_1st", FW'(first), FW'(0)); check("s1_lat", FW'(lat), FW'(2));
    check("s1_row3", FW'(CfgPortBankFlag[3*NB +: NB]), FW'(16'h000F));
    do_alloc(17, 2, 0, ok, first, lat);
    check("s2_ok", FW'(ok), FW'(1)); check("s2_1st", FW'(first), FW'(4));
    check("s2_row17", FW'(CfgPortBankFlag[17*NB +: NB]), FW'(16'h0030));
    do_alloc(5, 11, 0, ok, first, lat);
    check("s3_ok", FW'(ok), FW'(0)); check("s3_1st", FW'(first), FW'(0));
    check("s3_row5", FW'(CfgPortBankFlag[5*NB +: NB]), FW'(0));

    do_release(3);
    do_alloc(5, 4, 0, ok, first, lat);
    check("s4_ok", FW'(ok), FW'(1)); check("s4_1st", FW'(first), FW'(0));
    do_alloc(5, 1, 0, ok, first, lat);
    check("s5_ok", FW'(ok), FW'(0)); check("s5_lat", FW'(lat), FW'(1));

    // Release and allocation requested together: release wins this cycle.
    RlsVld = 1'b1; RlsPort = PW'(17);
    AllocReqVld = 1'b1; AllocReqPort = PW'(9); AllocReqNumBank = CW'(2);
    #1;
    check("coll_req_rdy", FW'(AllocReqRdy), FW'(0));
    check("coll_rls_rdy", FW'(RlsRdy), FW'(1));
    step();
    RlsVld = 1'b0;
    model_release(17);
    check("coll_row17", FW'(CfgPortBankFlag[17*NB +: NB]), FW'(0));
    do_alloc(9, 2, 0, ok, first, lat);
    check("s6_ok", FW'(ok), FW'(1)); check("s6_1st", FW'(first), FW'(4));

    do_alloc(7, 0, 5, ok, first, lat);
    check("s7_ok", FW'(ok), FW'(0)); check("s7_lat", FW'(lat), FW'(1));
    do_alloc(7, 17, 5, ok, first, lat);
    check("s8_ok", FW'(ok), FW'(0)); check("s8_lat", FW'(lat), FW'(1));
    do_alloc(30, 2, 1, ok, first, lat);
    check("s9_ok", FW'(ok), FW'(0)); check("s9_lat", FW'(lat), FW'(1));
    do_release(29);
    do_release(11);

    // Reset while searching: no response and no partial commit.
    AllocReqVld = 1'b1; AllocReqPort = PW'(2); AllocReqNumBank = CW'(10);
    step();
    AllocReqVld = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    model_reset();
    check("srst_flags", CfgPortBankFlag, FW'(0));
    check("srst_vld", FW'(AllocRspVld), FW'(0));
    check("srst_rdy", FW'(AllocReqRdy), FW'(0));
    rst_n = 1'b1;
    #1;
    check("srst_rdy_after", FW'(AllocReqRdy), FW'(1));
    for (int i = 0; i < 12; i++) begin
      step();
      check("srst_no_rsp", FW'(AllocRspVld), FW'(0));
    end

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_release(int'($urandom_range(0, 31)));
      end else begin
        int port, n;
        port = ($urandom_range(0, 7) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
        n    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 17)) : int'($urandom_range(1, 5));
        do_alloc(port, n, int'($urandom_range(0, 3)), ok, first, lat);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/glb_bank_alloc.md
GLB_BANK_ALLOC -- requirements
Module: glb_bank_alloc

Interface
REQ-001 SHALL have parameter NUM_BANK, default 16, meaning number of GLB banks.
REQ-002 SHALL have parameter NUM_PORT, default 24, meaning GLB write ports plus read ports; indices [0, NUM_WRPORT) are write ports and the remainder are read ports.
REQ-003 SHALL have port clk, input, width 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1, meaning reset; reset is synchronous and active-low.
REQ-005 SHALL have port AllocReqVld, input, width 1, meaning an allocation request is valid.
REQ-006 SHALL have port AllocReqRdy, output, width 1, meaning an allocation request is accepted.
REQ-007 SHALL have port AllocReqPort, input, width clog2(NUM_PORT), meaning the requesting port index.
REQ-008 SHALL have port AllocReqNumBank, input, width clog2(NUM_BANK)+1, meaning the number of contiguous banks requested.
REQ-009 SHALL have port AllocRspVld, output, width 1, meaning a response is valid.
REQ-010 SHALL have port AllocRspRdy, input, width 1, meaning the response is consumed.
REQ-011 SHALL have port AllocRspOk, output, width 1, meaning the allocation succeeded.
REQ-012 SHALL have port AllocRsp1stBank, output, width clog2(NUM_BANK), meaning the first allocated bank; it is 0 when the allocation failed.
REQ-013 SHALL have port RlsVld, input, width 1, meaning a release request is valid.
REQ-014 SHALL have port RlsRdy, output, width 1, meaning the release request is accepted.
REQ-015 SHALL have port RlsPort, input, width clog2(NUM_PORT), meaning the port whose banks are freed.
REQ-016 SHALL have port CfgPortBankFlag, output, width NUM_PORT x NUM_BANK, meaning the registered per-port bank ownership map that directly drives the GLB bank-flag configuration.
REQ-017 SHALL have port FreeBankMap, output, width NUM_BANK, meaning a bank is free, defined as the bitwise NOR over all ports of CfgPortBankFlag.

Function
REQ-018 The FSM SHALL have states IDLE, SEARCH and RSP.
REQ-019 AllocReqRdy SHALL be 1 only in IDLE when RlsVld=0; the allocation handshake is AllocReqVld & AllocReqRdy.
REQ-020 RlsRdy SHALL be 1 only in IDLE; release has priority over allocation in the same cycle.
REQ-021 On an accepted allocation, the block SHALL latch the port and count, set scan index SrchIdx=0, and go to SEARCH.
REQ-022 Exception to REQ-021: if the count is 0, the count exceeds NUM_BANK, or the port already owns any bank, the block SHALL go straight to RSP with Ok=0.
REQ-023 In SEARCH, the block SHALL test one window per cycle, covering banks [SrchIdx, SrchIdx+N-1]; windows do not wrap.
REQ-024 If every bank in the window is free, the block SHALL set those bits for the latched port in CfgPortBankFlag, record 1stBank=SrchIdx, and go to RSP with Ok=1.
REQ-025 Else, if SrchIdx+N >= NUM_BANK, the block SHALL go to RSP with Ok=0.
REQ-026 Else, the block SHALL increment SrchIdx by 1.
REQ-027 The block SHALL evaluate SrchIdx+N at width clog2(NUM_BANK)+2 so that no overflow occurs.
REQ-028 Latency from request acceptance to AllocRspVld SHALL be (found index)+2 cycles on success, and 1 cycle on immediate reject; the worst case is NUM_BANK+1 cycles.
REQ-029 In RSP, AllocRspVld, AllocRspOk and AllocRsp1stBank SHALL be held stable until AllocRspRdy=1; the FSM then returns to IDLE on the next edge.
REQ-030 An accepted release SHALL clear every CfgPortBankFlag bit of RlsPort on the next edge.
REQ-031 Releasing a port that owns no banks SHALL be a legal no-op.
REQ-032 CfgPortBankFlag SHALL change only on an allocation commit or an accepted release.
REQ-033 No bank SHALL ever be owned by more than one port.
REQ-034 A request with AllocReqPort >= NUM_PORT SHALL be rejected with Ok=0.
REQ-035 A release with RlsPort >= NUM_PORT SHALL be a no-op.

Reset
REQ-036 When rst_n=0 at a clock edge, the state SHALL become IDLE, CfgPortBankFlag all 0, FreeBankMap all 1, AllocRspVld=0, AllocRspOk=0, AllocRsp1stBank=0, and SrchIdx=0.
REQ-037 A reset in SEARCH or RSP SHALL abort the pending request without a response and without a partial commit.
REQ-038 AllocReqRdy and RlsRdy SHALL be 0 while rst_n=0.

Structure
REQ-039 The shared GLB package SHALL hold NUM_BANK, NUM_PORT, the derived index widths, and the FSM state enum.
REQ-040 The block SHALL contain one sub-module, glb_win_free_chk: a combinational check that the N-bank window starting at a given index is entirely free.
REQ-041 The port-owns-any-bank test SHALL be an OR-reduction of the port's row of CfgPortBankFlag.
REQ-042 All outputs SHALL be registered, except the Rdy signals and FreeBankMap.

Verification
REQ-043 Scenario: from reset, alloc port 3 with N=4 -> Ok=1, 1stBank=0, flag[3]=0x000F, latency 2 cycles.
REQ-044 Scenario: then alloc port 17 with N=2 -> Ok=1, 1stBank=4, flag[17]=0x0030; then alloc port 5 with N=11 -> Ok=0, 1stBank=0, and flags are unchanged.
REQ-045 Scenario: release port 3, then alloc port 5 with N=4 -> Ok=1, 1stBank=0; then alloc port 5 with N=1 -> Ok=0 with immediate reject (already owner).
REQ-046 Scenario: RlsVld and AllocReqVld asserted in the same IDLE cycle -> release accepted, AllocReqRdy=0 in that cycle, and the alloc is accepted the next cycle.
REQ-047 Scenario: alloc with N=0 and alloc with N=17 -> each gets Ok=1'b0 after 1 cycle; AllocRspRdy held low for 5 cycles -> response held stable.
REQ-048 Scenario: rst_n=0 asserted in SEARCH -> all flags 0, no AllocRspVld, and AllocReqRdy=1 on the first cycle after rst_n=1.
